// File: rtl/sqrt_seq.sv
// sqrt_seq: multi-cycle restoring square root, one root bit per clock.
// Produces floor(sqrt(in_data) * 2^FRAC_W) together with its remainder
// and an exactness flag. Operands and results use valid/ready handshakes.
module sqrt_seq #(
    parameter  int IN_W   = 8,
    parameter  int FRAC_W = 8,
    localparam int RW     = ((IN_W + 2*FRAC_W) % 2 == 1) ? (IN_W + 2*FRAC_W + 1) : (IN_W + 2*FRAC_W),
    localparam int OUT_W  = RW / 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_root,
    output logic [OUT_W:0]   out_rem,
    output logic             out_exact
);

    localparam int CW = (OUT_W > 1) ? $clog2(OUT_W) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state_q;
    logic [RW-1:0]    rad_q;
    logic [OUT_W-1:0] root_q;
    logic [OUT_W+1:0] rem_q;
    logic [CW-1:0]    cnt_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [OUT_W-1:0] out_root_q;
    logic [OUT_W:0]   out_rem_q;
    logic             out_exact_q;

    // Iteration datapath. rem <= 2*root bounds the partial remainder, so
    // OUT_W+2 bits hold every trial value and the top bits dropped by the
    // shift of rem are always zero.
    logic [OUT_W+1:0] r_shift;
    logic [OUT_W+1:0] t_val;
    logic [OUT_W+1:0] rem_nxt;
    logic [OUT_W:0]   root_ext;
    logic [OUT_W-1:0] root_nxt;

    // One restoring step: bring down two radicand bits and try a 1 root bit.
    always_comb begin
        r_shift  = {rem_q[OUT_W-1:0], rad_q[RW-1:RW-2]};
        t_val    = {root_q, 2'b01};
        root_ext = {root_q, 1'b0};
        rem_nxt  = r_shift;
        if (r_shift >= t_val) begin
            rem_nxt     = r_shift - t_val;
            root_ext[0] = 1'b1;
        end
        root_nxt = root_ext[OUT_W-1:0];
    end

    // Control FSM, iteration registers and registered result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rad_q       <= '0;
            root_q      <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_root_q  <= '0;
            out_rem_q   <= '0;
            out_exact_q <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        rad_q      <= RW'(in_data) << (2*FRAC_W);
                        root_q     <= '0;
                        rem_q      <= '0;
                        cnt_q      <= CW'(OUT_W - 1);
                        in_ready_q <= 1'b0;
                        state_q    <= CALC;
                    end else begin
                        // First cycle after reset raises in_ready here.
                        in_ready_q <= 1'b1;
                    end
                end
                CALC: begin
                    rad_q  <= rad_q << 2;
                    root_q <= root_nxt;
                    rem_q  <= rem_nxt;
                    if (cnt_q == '0) begin
                        out_root_q  <= root_nxt;
                        out_rem_q   <= rem_nxt[OUT_W:0];
                        out_exact_q <= (rem_nxt == '0);
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_root  = out_root_q;
    assign out_rem   = out_rem_q;
    assign out_exact = out_exact_q;

endmodule

// File: tb/tb_sqrt_seq.sv
// tb_sqrt_seq: randomized self-checking bench for sqrt_seq, with an
// arithmetic integer-square-root reference model.
module tb_sqrt_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Default instance: IN_W=8, FRAC_W=8 -> OUT_W=12
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready, out_exact;
    logic [7:0]  in_data;
    logic [11:0] out_root;
    logic [12:0] out_rem;

    sqrt_seq dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_root(out_root), .out_rem(out_rem), .out_exact(out_exact)
    );

    // Wide instance: IN_W=16, FRAC_W=0 -> OUT_W=8
    logic        in_valid2, in_ready2, out_valid2, out_ready2, out_exact2;
    logic [15:0] in_data2;
    logic [7:0]  out_root2;
    logic [8:0]  out_rem2;

    sqrt_seq #(.IN_W(16), .FRAC_W(0)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
        .in_data(in_data2), .out_valid(out_valid2), .out_ready(out_ready2),
        .out_root(out_root2), .out_rem(out_rem2), .out_exact(out_exact2)
    );

    // Reference: largest r with r*r <= n
    function automatic longint isqrt(input longint n);
        longint r;
        r = longint'($sqrt(real'(n)));
        while (r * r > n) r--;
        while ((r + 1) * (r + 1) <= n) r++;
        return r;
    endfunction

    // Offer one operand to the default instance, stall 'stall' cycles in DONE,
    // then consume. lat = -1 signals a handshake timeout.
    task automatic run_op(input logic [7:0] d, input int stall,
                          output longint root, output longint rem,
                          output logic exact, output int lat);
        int n;
        n = 0;
        lat = -1;
        while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
        in_valid = 1'b1; in_data = d;
        @(posedge clk); #1;
        in_valid = 1'b0; in_data = 8'($urandom);
        n = 0;
        while (n < 100) begin
            @(posedge clk); #1; n++;
            if (out_valid) begin lat = n; break; end
        end
        root = out_root; rem = out_rem; exact = out_exact;
        repeat (stall) @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic run_op2(input logic [15:0] d, output longint root,
                           output longint rem, output logic exact, output int lat);
        int n;
        n = 0;
        lat = -1;
        while (!in_ready2 && n < 50) begin @(posedge clk); #1; n++; end
        in_valid2 = 1'b1; in_data2 = d;
        @(posedge clk); #1;
        in_valid2 = 1'b0; in_data2 = 16'($urandom);
        n = 0;
        while (n < 100) begin
            @(posedge clk); #1; n++;
            if (out_valid2) begin lat = n; break; end
        end
        root = out_root2; rem = out_rem2; exact = out_exact2;
        out_ready2 = 1'b1;
        @(posedge clk); #1;
        out_ready2 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        tests++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_root !== 12'd0 ||
            out_rem !== 13'd0 || out_exact !== 1'b1) begin
            fails++;
            $display("FAIL reset_vals got rdy=%b vld=%b root=%0d rem=%0d ex=%b want 0 0 0 0 1",
                     in_ready, out_valid, out_root, out_rem, out_exact);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++; $display("FAIL reset_ready got %b want 1", in_ready);
        end
    endtask

    task automatic test_vectors();
        logic [7:0] vin[5]  = '{8'd255, 8'd4, 8'd1, 8'd0, 8'd2};
        longint     vrt[5]  = '{4087, 512, 256, 0, 362};
        longint     vrm[5]  = '{8111, 0, 0, 0, 28};
        logic       vex[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        longint root, rem; logic exact; int lat;
        for (int i = 0; i < 5; i++) begin
            run_op(vin[i], 0, root, rem, exact, lat);
            tests++;
            if (root !== vrt[i] || rem !== vrm[i] || exact !== vex[i] || lat != 12) begin
                fails++;
                $display("FAIL vector_%0d got root=%0d rem=%0d ex=%b lat=%0d want %0d %0d %b 12",
                         vin[i], root, rem, exact, lat, vrt[i], vrm[i], vex[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int n;
        longint root, rem; logic exact; int lat;
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'd4;
        @(posedge clk); #1;
        in_data = 8'd9;     // second operand held while busy
        n = 0;
        while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
        for (int i = 0; i < 20; i++) begin
            tests++;
            if (out_valid !== 1'b1 || out_root !== 12'd512 || in_ready !== 1'b0) begin
                fails++;
                $display("FAIL bp_hold cyc=%0d got vld=%b root=%0d rdy=%b want 1 512 0",
                         i, out_valid, out_root, in_ready);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL bp_release got rdy=%b vld=%b want 1 0", in_ready, out_valid);
        end
        @(posedge clk); #1;   // second operand accepted on this edge
        in_valid = 1'b0;
        tests++;
        if (in_ready !== 1'b0) begin
            fails++; $display("FAIL bp_second_accept got rdy=%b want 0", in_ready);
        end
        n = 0; lat = 1;
        while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
        root = out_root;
        tests++;
        if (root !== 768 || n != 12) begin
            fails++; $display("FAIL bp_second_result got root=%0d lat=%0d want 768 12", root, n);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int seen;
        longint root, rem; logic exact; int lat;
        in_valid = 1'b1; in_data = 8'd255;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        tests++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_root !== 12'd0 ||
            out_rem !== 13'd0 || out_exact !== 1'b1) begin
            fails++;
            $display("FAIL midrst_vals got rdy=%b vld=%b root=%0d rem=%0d ex=%b want 0 0 0 0 1",
                     in_ready, out_valid, out_root, out_rem, out_exact);
        end
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        tests++;
        if (seen != 0) begin
            fails++; $display("FAIL midrst_no_valid got %0d pulses want 0", seen);
        end
        run_op(8'd2, 0, root, rem, exact, lat);
        tests++;
        if (root !== 362 || rem !== 28 || lat != 12) begin
            fails++;
            $display("FAIL midrst_next got root=%0d rem=%0d lat=%0d want 362 28 12", root, rem, lat);
        end
    endtask

    task automatic test_wide();
        longint root, rem; logic exact; int lat;
        run_op2(16'd65535, root, rem, exact, lat);
        tests++;
        if (root !== 255 || rem !== 510 || exact !== 1'b0 || lat != 8) begin
            fails++;
            $display("FAIL wide_max got root=%0d rem=%0d ex=%b lat=%0d want 255 510 0 8",
                     root, rem, exact, lat);
        end
        run_op2(16'd65025, root, rem, exact, lat);
        tests++;
        if (root !== 255 || rem !== 0 || exact !== 1'b1) begin
            fails++;
            $display("FAIL wide_exact got root=%0d rem=%0d ex=%b want 255 0 1", root, rem, exact);
        end
        for (int i = 0; i < 8; i++) begin
            logic [15:0] d;
            longint er;
            d = 16'($urandom);
            er = isqrt(longint'(d));
            run_op2(d, root, rem, exact, lat);
            tests++;
            if (root !== er || rem !== (longint'(d) - er*er) || exact !== (longint'(d) == er*er)) begin
                fails++;
                $display("FAIL wide_rand in=%0d got root=%0d rem=%0d want %0d %0d",
                         d, root, rem, er, longint'(d) - er*er);
            end
        end
    endtask

    task automatic test_sweep();
        longint root, rem, n, er; logic exact; int lat;
        for (int v = 0; v < 256; v++) begin
            // Random out_ready noise while idle must be ignored.
            out_ready = 1'($urandom);
            @(posedge clk); #1;
            out_ready = 1'b0;
            run_op(8'(v), int'($urandom_range(0, 3)), root, rem, exact, lat);
            n  = longint'(v) << 16;
            er = isqrt(n);
            tests++;
            if (root != er || root*root + rem != n || rem > 2*root ||
                exact !== (rem == 0) || lat != 12) begin
                fails++;
                $display("FAIL sweep in=%0d got root=%0d rem=%0d ex=%b lat=%0d want root=%0d rem=%0d",
                         v, root, rem, exact, lat, er, n - er*er);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d;
        longint er;
        int hits[$];
        d = 8'($urandom_range(1, 255));
        er = isqrt(longint'(d) << 16);
        in_valid = 1'b1; in_data = d; out_ready = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                hits.push_back(c);
                tests++;
                if (out_root !== er) begin
                    fails++; $display("FAIL b2b_root got %0d want %0d", out_root, er);
                end
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;
        tests++;
        if (hits.size() < 3) begin
            fails++; $display("FAIL b2b_count got %0d results want >=3", hits.size());
        end else begin
            for (int i = 1; i < hits.size(); i++) begin
                tests++;
                if (hits[i] - hits[i-1] != 14) begin
                    fails++;
                    $display("FAIL b2b_period got %0d want 14", hits[i] - hits[i-1]);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        in_valid2 = 1'b0; in_data2 = '0; out_ready2 = 1'b0;
        test_reset();
        test_vectors();
        test_backpressure();
        test_reset_mid();
        test_wide();
        test_sweep();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
